// File: rtl/acc_pkg.sv
// Shared encodings for the accumulator result router: FSM states and destination select values.
package acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BUSY_A = 2'b01,
        ST_BUSY_B = 2'b10
    } state_t;

    localparam logic OP_SEL_A = 1'b0;
    localparam logic OP_SEL_B = 1'b1;

endpackage

// File: rtl/acc_xfer_counter.sv
// Wrapping transfer counter: increments on en, one-cycle update latency, never stalls.
module acc_xfer_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/acc_route_demux.sv
// 1-to-2 registered stream router: one-cycle latency, 1 word/cycle, single held word per port.
// Input stalls only while the held word's destination is not ready, or during Flush.
module acc_route_demux
    import acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Flush,
    input  logic [WIDTH-1:0] InData,
    input  logic             InValid,
    output logic             InReady,
    input  logic             OP,
    output logic [WIDTH-1:0] OutA,
    output logic             OutAValid,
    input  logic             OutAReady,
    output logic [WIDTH-1:0] OutB,
    output logic             OutBValid,
    input  logic             OutBReady,
    output logic [CNT_W-1:0] CountA,
    output logic [CNT_W-1:0] CountB
);

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   deliver_a;
    logic   deliver_b;

    assign OutAValid = (state == ST_BUSY_A);
    assign OutBValid = (state == ST_BUSY_B);

    // RST_N gates InReady so nothing upstream sees a ready while reset is asserted.
    assign InReady = RST_N && !Flush &&
                     ((state == ST_IDLE) ||
                      ((state == ST_BUSY_A) && OutAReady) ||
                      ((state == ST_BUSY_B) && OutBReady));

    assign accept    = InValid && InReady;
    assign deliver_a = OutAValid && OutAReady && !Flush;
    assign deliver_b = OutBValid && OutBReady && !Flush;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (Flush) begin
            state_nxt = ST_IDLE;
        end else if (accept) begin
            state_nxt = (OP == OP_SEL_B) ? ST_BUSY_B : ST_BUSY_A;
        end else if (deliver_a || deliver_b) begin
            state_nxt = ST_IDLE;
        end
    end

    // Data registers only load on accept; flush leaves the last word visible.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OutA <= '0;
            OutB <= '0;
        end else if (accept) begin
            if (OP == OP_SEL_A) begin
                OutA <= InData;
            end else begin
                OutB <= InData;
            end
        end
    end

    acc_xfer_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (deliver_a),
        .count (CountA)
    );

    acc_xfer_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (deliver_b),
        .count (CountB)
    );

endmodule

// File: tb/tb_acc_route_demux.sv
// Directed bench for acc_route_demux: hand-computed vectors checked with immediate assertions.
module tb_acc_route_demux;

    logic       CLK;
    logic       clk_en;
    logic       RST_N;
    logic       Flush;
    logic [7:0] InData;
    logic       InValid;
    logic       InReady;
    logic       OP;
    logic [7:0] OutA;
    logic       OutAValid;
    logic       OutAReady;
    logic [7:0] OutB;
    logic       OutBValid;
    logic       OutBReady;
    logic [3:0] CountA;
    logic [3:0] CountB;

    int vectors;
    int miscompares;

    acc_route_demux #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .Flush     (Flush),
        .InData    (InData),
        .InValid   (InValid),
        .InReady   (InReady),
        .OP        (OP),
        .OutA      (OutA),
        .OutAValid (OutAValid),
        .OutAReady (OutAReady),
        .OutB      (OutB),
        .OutBValid (OutBValid),
        .OutBReady (OutBReady),
        .CountA    (CountA),
        .CountB    (CountB)
    );

    initial CLK = 1'b0;
    always #5 CLK = clk_en ? ~CLK : CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_outa"},    32'(OutA), 32'h00);
        check({tag, "_outb"},    32'(OutB), 32'h00);
        check({tag, "_avalid"},  32'(OutAValid), 32'd0);
        check({tag, "_bvalid"},  32'(OutBValid), 32'd0);
        check({tag, "_counta"},  32'(CountA), 32'd0);
        check({tag, "_countb"},  32'(CountB), 32'd0);
        check({tag, "_inready"}, 32'(InReady), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk_en      = 1'b0;
        RST_N       = 1'b1;
        Flush       = 1'b0;
        InData      = 8'h00;
        InValid     = 1'b0;
        OP          = 1'b0;
        OutAReady   = 1'b0;
        OutBReady   = 1'b0;

        // Reset with the clock stopped: outputs must clear asynchronously.
        #5 RST_N = 1'b0;
        #1;
        check_reset_outputs("rst");

        clk_en = 1'b1;
        tick();
        tick();
        RST_N = 1'b1;
        #1;
        check("idle_inready", 32'(InReady), 32'd1);
        check("idle_avalid",  32'(OutAValid), 32'd0);
        check("idle_bvalid",  32'(OutBValid), 32'd0);

        // Basic route to A.
        InData = 8'hA5; OP = 1'b0; InValid = 1'b1; OutAReady = 1'b1;
        tick();
        InValid = 1'b0;
        check("basic_outa",   32'(OutA), 32'hA5);
        check("basic_avalid", 32'(OutAValid), 32'd1);
        check("basic_bvalid", 32'(OutBValid), 32'd0);
        check("basic_cnta0",  32'(CountA), 32'd0);
        tick();
        check("basic_cnta1",  32'(CountA), 32'd1);
        check("basic_idle_a", 32'(OutAValid), 32'd0);
        check("basic_idle_r", 32'(InReady), 32'd1);

        // Backpressure on B; changes to OP/InData without accept are ignored.
        OutBReady = 1'b0; OP = 1'b1; InData = 8'h3C; InValid = 1'b1;
        tick();
        InValid = 1'b0; OP = 1'b0; InData = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            check("bp_outb",    32'(OutB), 32'h3C);
            check("bp_bvalid",  32'(OutBValid), 32'd1);
            check("bp_inready", 32'(InReady), 32'd0);
            tick();
        end
        check("bp_cntb0", 32'(CountB), 32'd0);
        OutBReady = 1'b1;
        #1;
        check("bp_release_ready", 32'(InReady), 32'd1);
        tick();
        check("bp_cntb1",   32'(CountB), 32'd1);
        check("bp_bvalid0", 32'(OutBValid), 32'd0);
        check("bp_outa",    32'(OutA), 32'hA5);

        // Back-to-back port switching, no bubbles.
        OutAReady = 1'b1; OutBReady = 1'b1;
        InData = 8'h01; OP = 1'b0; InValid = 1'b1;
        tick();
        check("b2b_outa1",  32'(OutA), 32'h01);
        check("b2b_av1",    32'(OutAValid), 32'd1);
        check("b2b_rdy1",   32'(InReady), 32'd1);
        InData = 8'h02; OP = 1'b1;
        tick();
        check("b2b_outb2",  32'(OutB), 32'h02);
        check("b2b_bv2",    32'(OutBValid), 32'd1);
        check("b2b_av2",    32'(OutAValid), 32'd0);
        check("b2b_cnta2",  32'(CountA), 32'd2);
        InData = 8'h03; OP = 1'b0;
        tick();
        InValid = 1'b0;
        check("b2b_outa3",  32'(OutA), 32'h03);
        check("b2b_av3",    32'(OutAValid), 32'd1);
        check("b2b_bv3",    32'(OutBValid), 32'd0);
        check("b2b_cntb3",  32'(CountB), 32'd2);
        tick();
        check("b2b_cnta4",  32'(CountA), 32'd3);
        check("b2b_idle",   32'(OutAValid), 32'd0);

        // Flush drops a held word even with ready high, and blocks accept.
        OutAReady = 1'b0; InData = 8'h55; OP = 1'b0; InValid = 1'b1;
        tick();
        InValid = 1'b0;
        check("fl_held", 32'(OutAValid), 32'd1);
        Flush = 1'b1; OutAReady = 1'b1; InValid = 1'b1; OP = 1'b1; InData = 8'h77;
        #1;
        check("fl_inready", 32'(InReady), 32'd0);
        tick();
        Flush = 1'b0; InValid = 1'b0;
        check("fl_avalid", 32'(OutAValid), 32'd0);
        check("fl_bvalid", 32'(OutBValid), 32'd0);
        check("fl_cnta",   32'(CountA), 32'd3);
        check("fl_outa",   32'(OutA), 32'h55);
        check("fl_outb",   32'(OutB), 32'h02);

        // Wrap: 16 streamed words on A take CountA from 3 through 15 -> 0 and back to 3.
        OutAReady = 1'b1; OP = 1'b0;
        for (int i = 0; i < 16; i++) begin
            InData  = 8'(i + 8'h10);
            InValid = 1'b1;
            tick();
            check("wrap_outa", 32'(OutA), 32'(i + 8'h10));
            check("wrap_cnta", 32'(CountA), 32'((3 + i) % 16));
        end
        InValid = 1'b0;
        tick();
        check("wrap_final", 32'(CountA), 32'd3);
        check("wrap_idle",  32'(OutAValid), 32'd0);

        // Reset mid-transfer between clock edges.
        OutBReady = 1'b0; OP = 1'b1; InData = 8'h9E; InValid = 1'b1;
        tick();
        InValid = 1'b0;
        check("mid_bvalid", 32'(OutBValid), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        RST_N = 1'b1;
        #1;
        check("post_inready", 32'(InReady), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/acc_route_demux.md
Name: acc_route_demux

Overview:
Registered 1-to-2 stream router, the counterpart of the 1-bit A/B select mux. It takes one accumulator result stream and delivers each word to destination A (OP=0) or destination B (OP=1). Each path uses a valid/ready handshake. A single-entry output holding stage sustains throughput of 1 word/cycle. Per-destination transfer counters support debug and verification.

Parameters:
WIDTH, 8, data width of input and both outputs
CNT_W, 4, width of each per-destination transfer counter (wraps)

Ports:
CLK  input  1  single clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
Flush  input  1  synchronous drop of any held word
InData  input  WIDTH  input word
InValid  input  1  InData valid
InReady  output  1  router can accept this cycle
OP  input  1  destination select, sampled only on acceptance: 0 = A, 1 = B
OutA  output  WIDTH  destination A data
OutAValid  output  1  OutA holds an undelivered word
OutAReady  input  1  destination A accepts
OutB  output  WIDTH  destination B data
OutBValid  output  1  OutB holds an undelivered word
OutBReady  input  1  destination B accepts
CountA  output  CNT_W  words delivered on A
CountB  output  CNT_W  words delivered on B

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; OutA, OutB = 0; OutAValid, OutBValid = 0; CountA, CountB = 0; InReady forced 0 while RST_N is low.
- States: IDLE (nothing held), BUSY_A (word held on A), BUSY_B (word held on B). At most one output valid at any time.
- InReady (combinational) = !Flush && (IDLE || (BUSY_A && OutAReady) || (BUSY_B && OutBReady)).
- Accept = InValid && InReady. On accept:
  - OP=0: OutA <= InData, next state BUSY_A.
  - OP=1: OutB <= InData, next state BUSY_B.
  - Latency: input word appears on OutX with OutXValid=1 the cycle after acceptance.
- The non-selected output register holds its previous value; its valid is 0.
- Delivery = OutXValid && OutXReady.
  - Delivery with no accept: state goes to IDLE, valid clears next cycle.
  - Delivery and accept in the same cycle: held word counts as delivered and the new word loads. The new word may switch ports, e.g. BUSY_A to BUSY_B: OutAValid falls and OutBValid rises on the same edge.
- Held word is stable: OutX and OutXValid must not change while OutXValid=1 and OutXReady=0. OP and InData changes without accept are ignored.
- OutXReady while that output is not valid: no effect, counter unchanged.
- Counters: CountX += 1 on each delivery on X, modulo 2^CNT_W (15 -> 0 for CNT_W=4). Flush does not touch counters.
- Flush=1 (synchronous, highest priority):
  - Next state IDLE; both valids cleared.
  - Held word dropped and not counted, even if OutXReady=1 that cycle.
  - No accept that cycle (InReady=0).
  - Data registers keep their values.
- Reset mid-transfer: held word is lost; all outputs return to reset values immediately, without waiting for CLK.

Decomposition:
- acc_pkg: state encoding (ST_IDLE=2'b00, ST_BUSY_A=2'b01, ST_BUSY_B=2'b10) and select constants (OP_SEL_A=1'b0, OP_SEL_B=1'b1).
- Sub-module acc_xfer_counter: CNT_W-bit wrapping counter with enable and async active-low reset, instantiated twice (A and B).
- Router FSM and data registers stay in acc_route_demux.

Test Plan:
- Reset then idle: RST_N=0 at 5 ns with CLK stopped → all outputs 0 immediately. Release reset → InReady=1, both valids 0.
- Basic route: InData=8'hA5, OP=0, InValid=1 for one cycle, OutAReady=1 → next cycle OutA=A5, OutAValid=1, OutBValid=0. Following cycle CountA=1, state IDLE.
- Backpressure: OP=1, InData=8'h3C, OutBReady=0 for 4 cycles → OutB=3C held stable with OutBValid=1 and InReady=0. Release OutBReady → CountB=1 one cycle later.
- Back-to-back port switch: stream 01 (OP=0), 02 (OP=1), 03 (OP=0) with both readies=1 → one word per cycle. A gets 01 then 03, B gets 02. CountA=2, CountB=1, no bubbles.
- Flush and wrap: hold word on A with OutAReady=0, pulse Flush → OutAValid=0 next cycle, CountA unchanged. Then deliver 16 words on A → CountA wraps 15 -> 0.
